// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first ripple through a single full adder, WIDTH+1 bit registered result.
// Define SERIAL_ADDER_SUB_EN to add an op input selecting a - b (a + ~b + 1).
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             op,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   sum,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH:0]     sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               sum_bit;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sum_bit = a_q[0] ^ b_q[0] ^ carry_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
`ifdef SERIAL_ADDER_SUB_EN
               // Subtraction is two's-complement addition: invert B, seed carry with 1.
               b_d     = op ? ~b : b;
               carry_d = op;
`else
               b_d     = b;
               carry_d = 1'b0;
`endif
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = {sum_bit, res_q[WIDTH-1:1]};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // sum only moves here so the display never sees a partial result.
            sum_d   = {carry_q, res_q};
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign sum  = sum_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
